// File: rtl/i2s_tx_feeder.sv
// i2s_tx_feeder: FIFO-buffered stereo sample source that advances one pair per I2S frame
module i2s_tx_feeder #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3,
  parameter bit MUTE_ON_UNDERFLOW = 1'b1
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              lrclk,
  output logic [DATA_W-1:0] left_chan,
  output logic [DATA_W-1:0] right_chan,
  output logic [ADDR_W:0]   level,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic lrclk_d, fr, push, pop, empty;
  assign empty = level == '0;
  assign s_ready = level != FULL;
  // Rising lrclk marks the start of the right slot: half a frame before i2s_top latches the pair
  assign fr = lrclk & ~lrclk_d;
  assign push = s_valid & s_ready;
  assign pop = fr & ~empty;
  always_ff @(posedge sclk)
    if (push && !rst) mem[wr_ptr] <= {s_left, s_right};
  always_ff @(posedge sclk) begin
    lrclk_d <= lrclk;
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      underflow <= 1'b0;
      underflow_cnt <= '0;
      left_chan <= '0;
      right_chan <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(push);
      rd_ptr <= rd_ptr + ADDR_W'(pop);
      level <= (push == pop) ? level : push ? level + 1'b1 : level - 1'b1;
      underflow <= fr & empty;
      if (fr && empty && (underflow_cnt != 16'hFFFF)) underflow_cnt <= underflow_cnt + 16'd1;
      if (pop) {left_chan, right_chan} <= mem[rd_ptr];
      else if (fr && MUTE_ON_UNDERFLOW) {left_chan, right_chan} <= '0;
    end
  end
endmodule

// File: tb/tb_i2s_tx_feeder.sv
// tb_i2s_tx_feeder: muting and repeating feeders driven together, checked against a queue model
module tb_i2s_tx_feeder;
  logic sclk = 0, rst = 1, s_valid = 0, lrclk = 1;
  logic [31:0] s_left = 0, s_right = 0;
  logic rdy0, rdy1, u0, u1;
  logic [31:0] l0, r0, l1, r1;
  logic [3:0] lv0, lv1;
  logic [15:0] c0, c1;
  int total = 0, bad = 0;

  i2s_tx_feeder #(.MUTE_ON_UNDERFLOW(1'b1)) dut0 (
    .sclk(sclk), .rst(rst), .s_valid(s_valid), .s_ready(rdy0), .s_left(s_left), .s_right(s_right),
    .lrclk(lrclk), .left_chan(l0), .right_chan(r0), .level(lv0), .underflow(u0), .underflow_cnt(c0));
  i2s_tx_feeder #(.MUTE_ON_UNDERFLOW(1'b0)) dut1 (
    .sclk(sclk), .rst(rst), .s_valid(s_valid), .s_ready(rdy1), .s_left(s_left), .s_right(s_right),
    .lrclk(lrclk), .left_chan(l1), .right_chan(r1), .level(lv1), .underflow(u1), .underflow_cnt(c1));

  always #5 sclk = ~sclk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue of pairs; each frame start takes the oldest pair or records an underflow
  logic [63:0] q[$];
  logic [31:0] ml[2], mr[2];
  logic muf = 0, plr = 0, started = 0;
  int mcnt = 0;
  always @(posedge sclk) begin
    logic e, ready;
    logic [63:0] p;
    started = 1;
    if (rst) begin
      q.delete();
      ml = '{0, 0};
      mr = '{0, 0};
      muf = 0;
      mcnt = 0;
    end else begin
      e = lrclk && !plr;
      ready = q.size() != 8;
      muf = 0;
      if (e) begin
        if (q.size() > 0) begin
          p = q.pop_front();
          ml = '{p[63:32], p[63:32]};
          mr = '{p[31:0], p[31:0]};
        end else begin
          muf = 1;
          if (mcnt != 16'hFFFF) mcnt++;
          ml[0] = 0;
          mr[0] = 0;
        end
      end
      if (s_valid && ready) q.push_back({s_left, s_right});
    end
    plr = lrclk;
  end

  always @(negedge sclk) if (started) begin
    cmp("level0", lv0, q.size());
    cmp("level1", lv1, q.size());
    cmp("ready0", rdy0, q.size() != 8);
    cmp("ready1", rdy1, q.size() != 8);
    cmp("uf0", u0, muf);
    cmp("uf1", u1, muf);
    cmp("cnt0", c0, mcnt);
    cmp("cnt1", c1, mcnt);
    cmp("mute_lr", {l0, r0}, {ml[0], mr[0]});
    cmp("hold_lr", {l1, r1}, {ml[1], mr[1]});
  end

  task automatic tick(input logic v, input logic [31:0] l, input logic [31:0] r, input logic lr);
    s_valid = v;
    s_left = l;
    s_right = r;
    lrclk = lr;
    @(posedge sclk);
    #1;
  endtask

  initial begin
    int half, phase_v;
    repeat (2) @(posedge sclk);
    #1 rst = 0;
    tick(0, 0, 0, 1);
    cmp("lit_rst_uf", u0, 0);
    cmp("lit_rst_level", lv0, 0);
    cmp("lit_rst_ready", rdy0, 1);
    cmp("lit_rst_left", l0, 0);
    tick(1, 32'h01234567, 32'h89abcdef, 0);
    cmp("lit_push_level", lv0, 1);
    tick(0, 0, 0, 1);
    cmp("lit_pop_left", l0, 32'h01234567);
    cmp("lit_pop_right", r0, 32'h89abcdef);
    cmp("lit_pop_level", lv0, 0);
    cmp("lit_model_left", ml[0], 32'h01234567);
    for (int i = 0; i < 9; i++) tick(1, 32'h1000 + i, 32'h2000 + i, 0);
    cmp("lit_full_level", lv0, 8);
    cmp("lit_full_ready", rdy0, 0);
    tick(0, 0, 0, 1);
    cmp("lit_full_pop_left", l0, 32'h1000);
    cmp("lit_full_pop_level", lv0, 7);
    cmp("lit_full_pop_ready", rdy0, 1);
    repeat (7) begin
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 1);
    end
    cmp("lit_drain_left", l0, 32'h1007);
    cmp("lit_drain_level", lv0, 0);
    repeat (3) begin
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 1);
      cmp("lit_uf_pulse", u0, 1);
    end
    tick(0, 0, 0, 0);
    cmp("lit_uf_clear", u0, 0);
    cmp("lit_uf_cnt", c0, 3);
    cmp("lit_model_cnt", mcnt, 3);
    cmp("lit_mute_left", l0, 0);
    cmp("lit_hold_left", l1, 32'h1007);
    cmp("lit_hold_right", r1, 32'h2007);
    tick(1, 32'h3000, 32'h4000, 0);
    tick(1, 32'h3001, 32'h4001, 0);
    tick(1, 32'h3002, 32'h4002, 1);
    cmp("lit_coinc_level", lv0, 2);
    cmp("lit_coinc_left", l0, 32'h3000);
    for (int i = 3; i < 6; i++) tick(1, 32'h3000 + i, 32'h4000 + i, 0);
    cmp("lit_pre_rst_level", lv0, 5);
    rst = 1;
    tick(0, 0, 0, 0);
    rst = 0;
    cmp("lit_mid_rst_level", lv0, 0);
    cmp("lit_mid_rst_cnt", c0, 0);
    cmp("lit_mid_rst_left", l1, 0);
    tick(1, 32'h5555, 32'h6666, 0);
    tick(0, 0, 0, 1);
    cmp("lit_after_rst_left", l1, 32'h5555);
    cmp("lit_after_rst_right", r0, 32'h6666);
    half = 1;
    phase_v = 50;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) phase_v = $urandom_range(5, 95);
      if (--half == 0) begin
        half = $urandom_range(1, 6);
        lrclk = ~lrclk;
      end
      rst = ($urandom_range(0, 499) == 0);
      tick($urandom_range(0, 99) < phase_v, $urandom, $urandom, lrclk);
    end
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
